// File: rtl/ula_sequencial.sv
// ula_sequencial: multicycle 32-bit ALU.
// Logic/arithmetic ops complete in one cycle after acceptance. Shifts walk
// one bit position per clock through a captured copy of b, then finish
// through the same EXEC state that registers every result.
module ula_sequencial (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        overflow,
    output logic        erro,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLLV = 5'd11;
    localparam logic [4:0] OP_SRLV = 5'd12;
    localparam logic [4:0] OP_SRAV = 5'd13;

    state_t      state_reg, state_next;
    logic [4:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;        // doubles as the shift register for shift ops
    logic [4:0]  cnt_reg;      // remaining shift steps

    logic [31:0] resultado_reg;
    logic        zero_reg;
    logic        overflow_reg;
    logic        erro_reg;
    logic        done_reg;

    logic        accept;
    logic        is_shift_in;
    logic [4:0]  n_in;
    logic [31:0] shift_step;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_erro;

    // start is only honoured while idle, which is exactly when busy is low.
    assign accept      = start && (state_reg == IDLE);
    assign is_shift_in = (op >= OP_SLL) && (op <= OP_SRAV);
    // Fixed shifts use shamt, variable shifts use the low bits of a.
    assign n_in        = (op <= OP_SRA) ? shamt : a[4:0];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: zero-amount shifts skip SHIFT and finish like any other op.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_shift_in && (n_in != 5'd0)) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            SHIFT: begin
                if (cnt_reg <= 5'd1) begin
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-bit shift of the working value, direction and fill chosen by op.
    always_comb begin
        case (op_reg)
            OP_SLL, OP_SLLV: shift_step = {b_reg[30:0], 1'b0};
            OP_SRA, OP_SRAV: shift_step = {b_reg[31], b_reg[31:1]};
            default:         shift_step = {1'b0, b_reg[31:1]};
        endcase
    end

    // Operand capture on acceptance, then one shift step per SHIFT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg  <= 5'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            cnt_reg <= 5'd0;
        end else if (accept) begin
            op_reg  <= op;
            a_reg   <= a;
            b_reg   <= b;
            cnt_reg <= is_shift_in ? n_in : 5'd0;
        end else if (state_reg == SHIFT) begin
            b_reg   <= shift_step;
            cnt_reg <= cnt_reg - 5'd1;
        end
    end

    assign sum  = a_reg + b_reg;
    assign diff = a_reg - b_reg;

    // Final result selection; shift ops simply pass the already-shifted b_reg.
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        alu_erro     = 1'b0;
        case (op_reg)
            OP_AND:  alu_result = a_reg & b_reg;
            OP_OR:   alu_result = a_reg | b_reg;
            OP_ADD: begin
                alu_result   = sum;
                alu_overflow = (a_reg[31] == b_reg[31]) && (sum[31] != a_reg[31]);
            end
            OP_XOR:  alu_result = a_reg ^ b_reg;
            OP_NOR:  alu_result = ~(a_reg | b_reg);
            OP_SLT:  alu_result = {31'd0, ($signed(a_reg) < $signed(b_reg))};
            OP_SUB: begin
                alu_result   = diff;
                alu_overflow = (a_reg[31] != b_reg[31]) && (diff[31] != a_reg[31]);
            end
            OP_SLTU: alu_result = {31'd0, (a_reg < b_reg)};
            OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV: alu_result = b_reg;
            default: alu_erro = 1'b1;
        endcase
    end

    // Result registers load only from EXEC, so they hold between completions.
    always_ff @(posedge clock) begin
        if (reset) begin
            resultado_reg <= 32'd0;
            zero_reg      <= 1'b1;
            overflow_reg  <= 1'b0;
            erro_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == EXEC);
            if (state_reg == EXEC) begin
                resultado_reg <= alu_result;
                zero_reg      <= (alu_result == 32'd0);
                overflow_reg  <= alu_overflow;
                erro_reg      <= alu_erro;
            end
        end
    end

    // Outputs: busy while any operation is in flight, everything else registered.
    always_comb begin
        busy      = (state_reg != IDLE);
        done      = done_reg;
        resultado = resultado_reg;
        zero      = zero_reg;
        overflow  = overflow_reg;
        erro      = erro_reg;
    end

endmodule
